// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT input loader: sizes, bank-state encoding
// and the base-4 digit reversal used to place samples (optional FFT_IN_PRESCALE_EN build).
package fft_pkg;

    localparam int FFT_N = 16;
    localparam int FFT_W = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Complete loader state in one struct so it can be probed as a unit.
    typedef struct packed {
        bank_state_t [1:0] bank;
        logic              wr_bank;
        logic              rd_bank;
        logic [3:0]        wr_idx;
        logic              align_err;
    } loader_state_t;

    // Swap the two base-4 digits: k = 4*d1 + d0  ->  p = 4*d0 + d1.
    function automatic logic [3:0] digit_rev(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 16 x 32-bit frame buffer: single indexed write port, whole frame visible as a flat bus.
// Unaffected by FFT_IN_PRESCALE_EN; the loader decides what gets written.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [3:0]               widx,
    input  logic [FFT_W-1:0]         wdata,
    output logic [FFT_W*FFT_N-1:0]   flat
);

    logic [FFT_W-1:0] mem [FFT_N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    always_comb begin
        flat = '0;
        for (int i = 0; i < FFT_N; i++) begin
            flat[i*FFT_W +: FFT_W] = mem[i];
        end
    end

endmodule

// File: rtl/fft_input_loader_16.sv
// Ping-pong loader: serial real samples in, digit-reversed 16-word frame out with a one-cycle strobe.
// Define FFT_IN_PRESCALE_EN to store each sample as (x + 8) >>> 4 instead of the plain sign extension.
module fft_input_loader_16
    import fft_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int N    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic                     launch_en,
    output logic [FFT_W*FFT_N-1:0]   data_real_in_flat,
    output logic                     ready,
    output logic [7:0]               frame_cnt,
    output logic                     align_err
);

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    // Handshake: a sample transfers on any rising edge where s_valid && s_ready;
    // s_ready depends on registered state only, never on s_valid.
    loader_state_t st, st_nx;

    logic                     accept;
    logic                     launch;
    logic [1:0]               bank_we;
    logic signed [FFT_W-1:0]  sample_ext;
    logic [FFT_W-1:0]         wdata;
    logic [FFT_W*FFT_N-1:0]   bank_flat [2];

    assign s_ready   = (st.bank[st.wr_bank] != BANK_FULL);
    assign accept    = s_valid && s_ready;
    assign launch    = (st.bank[st.rd_bank] == BANK_FULL) && launch_en;
    assign align_err = st.align_err;

    assign sample_ext = {{(FFT_W-IN_W){s_data[IN_W-1]}}, s_data};
`ifdef FFT_IN_PRESCALE_EN
    assign wdata = (sample_ext + 32'sd8) >>> 4;
`else
    assign wdata = sample_ext;
`endif

    assign bank_we[0] = accept && !st.wr_bank;
    assign bank_we[1] = accept &&  st.wr_bank;

    fft_frame_bank u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we[0]),
        .widx  (digit_rev(st.wr_idx)),
        .wdata (wdata),
        .flat  (bank_flat[0])
    );

    fft_frame_bank u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we[1]),
        .widx  (digit_rev(st.wr_idx)),
        .wdata (wdata),
        .flat  (bank_flat[1])
    );

    // Launch and accept never target the same bank: launch needs FULL, accept needs not-FULL.
    always_comb begin
        st_nx = st;
        if (launch) begin
            st_nx.bank[st.rd_bank] = BANK_EMPTY;
            st_nx.rd_bank          = ~st.rd_bank;
        end
        if (accept) begin
            if (st.wr_idx == LAST_IDX) begin
                st_nx.bank[st.wr_bank] = BANK_FULL;
                st_nx.wr_bank          = ~st.wr_bank;
                st_nx.wr_idx           = '0;
                if (!s_last) begin
                    st_nx.align_err = 1'b1;
                end
            end else if (s_last) begin
                // Early s_last: drop the partial frame and refill the same bank.
                st_nx.bank[st.wr_bank] = BANK_EMPTY;
                st_nx.wr_idx           = '0;
                st_nx.align_err        = 1'b1;
            end else begin
                st_nx.bank[st.wr_bank] = BANK_FILLING;
                st_nx.wr_idx           = 4'(st.wr_idx + 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st.bank[0]   <= BANK_EMPTY;
            st.bank[1]   <= BANK_EMPTY;
            st.wr_bank   <= 1'b0;
            st.rd_bank   <= 1'b0;
            st.wr_idx    <= '0;
            st.align_err <= 1'b0;
        end else begin
            st <= st_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_real_in_flat <= '0;
            ready             <= 1'b0;
            frame_cnt         <= '0;
        end else begin
            ready <= launch;
            if (launch) begin
                data_real_in_flat <= st.rd_bank ? bank_flat[1] : bank_flat[0];
                frame_cnt         <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader_16.sv
// Bench for fft_input_loader_16: random/ramp frames checked each cycle against a frame-queue model.
// Compile with FFT_IN_PRESCALE_EN defined to exercise the prescaled build.
module tb_fft_input_loader_16;

    localparam int IN_W = 16;
    localparam int FW   = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [IN_W-1:0] s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic            launch_en = 1'b0;
    logic [FW-1:0]   data_real_in_flat;
    logic            ready;
    logic [7:0]      frame_cnt;
    logic            align_err;

    fft_input_loader_16 #(.IN_W(IN_W), .N(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_last            (s_last),
        .s_ready           (s_ready),
        .launch_en         (launch_en),
        .data_real_in_flat (data_real_in_flat),
        .ready             (ready),
        .frame_cnt         (frame_cnt),
        .align_err         (align_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [FW-1:0] exp_q[$];     // completed frames waiting for launch
    logic [31:0]   cur_q[$];     // samples of the frame being received, time order
    logic [FW-1:0] exp_flat;
    logic          exp_ready;
    logic          exp_err;
    logic          mon_s_ready;
    int            n_launch;
    int            ready_seen = 0;

    function automatic logic [31:0] store_val(input logic [IN_W-1:0] s);
        int v;
        v = int'($signed(s));
`ifdef FFT_IN_PRESCALE_EN
        v = (v + 8) >>> 4;
`endif
        return v;
    endfunction

    function automatic logic [FW-1:0] pack_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            f[(4 * (k % 4) + k / 4) * 32 +: 32] = cur_q[k];
        end
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            cur_q.delete();
            exp_flat  = '0;
            exp_ready = 1'b0;
            exp_err   = 1'b0;
            n_launch  = 0;
        end else begin
            mon_s_ready = (exp_q.size() < 2);
            check("s_ready", s_ready, mon_s_ready);
            check("ready", ready, exp_ready);
            check("flat", data_real_in_flat, exp_flat);
            check("frame_cnt", frame_cnt, 8'(n_launch));
            check("align_err", align_err, exp_err);
            if (ready) ready_seen++;
            // effect of the coming rising edge
            exp_ready = 1'b0;
            if (launch_en && exp_q.size() > 0) begin
                exp_flat  = exp_q.pop_front();
                exp_ready = 1'b1;
                n_launch++;
            end
            if (s_valid && mon_s_ready) begin
                cur_q.push_back(store_val(s_data));
                if (cur_q.size() == 16) begin
                    exp_q.push_back(pack_frame());
                    cur_q.delete();
                    if (!s_last) exp_err = 1'b1;
                end else if (s_last) begin
                    cur_q.delete();
                    exp_err = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [IN_W-1:0] frame_data [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int base);
        for (int k = 0; k < 16; k++) frame_data[k] = IN_W'(base + k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 16; k++) frame_data[k] = IN_W'($urandom);
    endtask

    task automatic send_sample(input logic [IN_W-1:0] d, input logic last, input int gap);
        logic acc;
        int   t;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (gap) step();
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = s_ready;
            step();
            t++;
        end
        check("accept_wait", acc, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input int gap_max);
        for (int k = 0; k < n; k++) begin
            send_sample(frame_data[k], (k == last_at), (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
        end
    endtask

    task automatic wait_ready(input int bound);
        logic got;
        int   t;
        got = 1'b0;
        t   = 0;
        while (!got && t < bound) begin
            @(negedge clk);
            got = ready;
            t++;
        end
        step();
        check("ready_wait", got, 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    // ---------------- test sequence ----------------
    int base_seen;

    initial begin
        repeat (3) step();
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_ready", ready, 1'b0);
        check("rst_flat", data_real_in_flat, '0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        check("rst_align_err", align_err, 1'b0);
        rst = 1'b1;
        step();

        // ramp frame, immediate launch
        launch_en = 1'b1;
        fill_ramp(0);
        send_frame(16, 15, 0);
        @(negedge clk);
        check("ramp_ready_t1", ready, 1'b0);
        @(negedge clk);
        check("ramp_ready_t2", ready, 1'b1);
        check("ramp_p4", data_real_in_flat[4*32 +: 32], store_val(16'd1));
        check("ramp_p1", data_real_in_flat[1*32 +: 32], store_val(16'd4));
        check("ramp_p5", data_real_in_flat[5*32 +: 32], store_val(16'd5));
        check("ramp_p15", data_real_in_flat[15*32 +: 32], store_val(16'd15));
        check("ramp_cnt", frame_cnt, 8'd1);
        step();

        // two frames held back, third stalls until launches resume
        launch_en = 1'b0;
        base_seen = ready_seen;
        fill_ramp(16);
        send_frame(16, 15, 0);
        fill_ramp(32);
        send_frame(16, 15, 0);
        @(negedge clk);
        check("full_s_ready", s_ready, 1'b0);
        step();
        fill_ramp(48);
        fork
            send_frame(16, 15, 0);
            begin
                repeat (6) step();
                launch_en = 1'b1;
            end
        join
        repeat (5) step();
        check("bp_ready_count", ready_seen - base_seen, 3);
        check("bp_cnt", frame_cnt, 8'd4);

        // early s_last discards the partial frame
        base_seen = ready_seen;
        fill_ramp(100);
        send_frame(7, 6, 0);
        repeat (5) step();
        check("early_last_err", align_err, 1'b1);
        check("early_last_no_ready", ready_seen - base_seen, 0);
        fill_ramp(200);
        send_frame(16, 15, 0);
        wait_ready(10);
        check("after_err_cnt", frame_cnt, 8'd5);

        // asynchronous reset in the middle of a frame
        fill_ramp(300);
        send_frame(9, -1, 0);
        s_data  = frame_data[9];
        s_valid = 1'b1;
        rst     = 1'b0;
        #1;
        check("midrst_ready", ready, 1'b0);
        check("midrst_flat", data_real_in_flat, '0);
        check("midrst_cnt", frame_cnt, 8'd0);
        check("midrst_err", align_err, 1'b0);
        check("midrst_s_ready", s_ready, 1'b1);
        s_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        fill_rand();
        send_frame(16, 15, 0);
        wait_ready(10);
        check("postrst_cnt", frame_cnt, 8'd1);
        check("postrst_p4", data_real_in_flat[4*32 +: 32], store_val(frame_data[1]));

        // ten random frames with random valid gaps
        pulse_reset();
        base_seen = ready_seen;
        for (int f = 0; f < 10; f++) begin
            fill_rand();
            send_frame(16, 15, 3);
        end
        repeat (6) step();
        check("stream_ready_count", ready_seen - base_seen, 10);
        check("stream_cnt", frame_cnt, 8'd10);
        check("stream_err", align_err, 1'b0);

        // 16th sample without s_last still completes the frame
        fill_rand();
        send_frame(16, -1, 0);
        wait_ready(10);
        check("nolast_err", align_err, 1'b1);
        check("nolast_cnt", frame_cnt, 8'd11);

        // storage transform for a few fixed values
        pulse_reset();
        fill_rand();
        frame_data[0] = -16'sd8;
        frame_data[1] = 16'sd24;
        frame_data[2] = -16'sd24;
        frame_data[3] = 16'sd32767;
        send_frame(16, 15, 0);
        wait_ready(10);
`ifdef FFT_IN_PRESCALE_EN
        check("scale_m8", data_real_in_flat[0*32 +: 32], 32'd0);
        check("scale_24", data_real_in_flat[4*32 +: 32], 32'd2);
        check("scale_m24", data_real_in_flat[8*32 +: 32], 32'hFFFF_FFFF);
        check("scale_max", data_real_in_flat[12*32 +: 32], 32'd2048);
`else
        check("plain_m8", data_real_in_flat[0*32 +: 32], 32'hFFFF_FFF8);
        check("plain_24", data_real_in_flat[4*32 +: 32], 32'd24);
        check("plain_m24", data_real_in_flat[8*32 +: 32], 32'hFFFF_FFE8);
        check("plain_max", data_real_in_flat[12*32 +: 32], 32'd32767);
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_input_loader_16.md
Name: fft_input_loader_16

Overview:
- Front end of the 16-point radix-4 real FFT. Accepts a serial stream of real samples over a valid/ready handshake and reorders each frame into base-4 digit-reversed order.
- Presents each complete frame as a 512-bit flat bus with a one-cycle `ready` strobe, which is what the FFT stage's first butterfly layer expects.
- Double-buffered (ping-pong), so the stream can continue into one bank while the other waits for launch.

Parameters:
- IN_W, 16, input sample width; samples are sign-extended to 32 bits on write.
- N, 16, samples per frame; fixed at 16, and the digit-reversal table is defined only for 16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- s_data  input  IN_W  signed real sample, natural time order.
- s_valid  input  1  sample valid.
- s_last  input  1  marks the sample the producer believes is the 16th of its frame.
- s_ready  output  1  loader can accept a sample.
- launch_en  input  1  downstream permits a frame launch this cycle.
- data_real_in_flat  output  512  frame; word p sits at bits [32p+31:32p].
- ready  output  1  one-cycle strobe; data_real_in_flat is valid in the same cycle.
- frame_cnt  output  8  launched-frame counter, wraps at 255 to 0.
- align_err  output  1  sticky framing-error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - Both banks EMPTY, write index 0, write bank 0, read bank 0.
  - s_ready=1, ready=0, data_real_in_flat=0, frame_cnt=0, align_err=0.
- Sample accept occurs when s_valid && s_ready.
  - Sample number k (0..15) is written to bank word p = 4*(k%4) + k/4.
  - Examples: k=1 goes to p=4; k=4 goes to p=1; k=15 goes to p=15.
- Bank state: EMPTY to FILLING on the first accepted sample; FILLING to FULL on accept of k=15.
  - At the FULL transition, the write bank toggles and the index resets to 0.
- s_ready = 1 unless the current write bank is FULL (i.e. both banks are FULL). It is combinational from registered state only.
- Launch condition: read bank FULL && launch_en.
  - Registers bank contents into data_real_in_flat.
  - Asserts ready for exactly one cycle.
  - Marks the bank EMPTY, toggles the read bank, and increments frame_cnt.
- Latency: accept of k=15 at cycle t gives FULL at t+1. With launch_en high, ready is asserted in cycle t+2.
- data_real_in_flat holds its value between launches; it changes only on a launch edge.
- Minimum launch spacing is 1 cycle. With back-to-back frames, ready pulses every 16 cycles at full input rate.
- Simultaneous events:
  - If a bank completes fill in the same cycle the other bank launches, both actions happen; there is no lost cycle.
  - If the freed bank is the current write bank, s_ready rises the next cycle.
- s_last handling:
  - s_last on k=15 is the normal case.
  - s_last on k<15: the sample is accepted, the partial frame is discarded (bank back to EMPTY, index 0, no toggle), and align_err is set.
  - k=15 without s_last: the frame completes normally and align_err is set.
- align_err is cleared only by reset.
- Reset mid-fill or mid-launch: all data is discarded and no ready pulse is emitted.

Optional Feature:
- Macro: FFT_IN_PRESCALE_EN.
- Defined: each sign-extended sample is arithmetically shifted right by 4 with round-half-up (add 8, then >>>4) before storage. This compensates for the worst-case 16x gain of two radix-4 stages.
  - Examples: input -8 stores 0; input 24 stores 2; input -24 stores -1.
- Undefined: the plain sign-extended sample is stored.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N=16 and FFT_W=32.
  - The bank-state encoding (EMPTY, FILLING, FULL).
  - The digit-reverse function for 2-digit base-4 indices.
- One sub-module, fft_frame_bank: 16x32 register file with write-enable/index and a flat read-out. It is instantiated twice.

Test Plan:
- Ramp 0..15 sent continuously, s_last on 15, launch_en=1 -> one ready pulse 2 cycles after the last accept; word p=4 holds 1, p=1 holds 4, p=5 holds 5, p=15 holds 15; frame_cnt=1.
- Three back-to-back ramp frames with launch_en=0 -> s_ready drops after the 32nd accept. Then raise launch_en -> two ready pulses on consecutive launch opportunities, in order, with no data corruption; the third frame then fills.
- s_last at k=6 -> align_err=1, no ready pulse; the next correct 16-sample frame launches normally.
- rst low asserted at k=9 -> outputs return to reset values immediately; after release, a fresh frame launches with correct contents.
- Full-rate stream of 10 frames with random s_valid gaps -> ready count = 10, frame_cnt=10, and every frame matches the digit-reversed model.
- With FFT_IN_PRESCALE_EN: inputs -8, 24, -24, 32767 store 0, 2, -1, 2048 at their digit-reversed positions.
